// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//
// Request/response bus between a CPU memory port (initiator) and the
// mem_responder target.
//
// Request channel (valid/ready, initiator -> target):
//   req_valid  request present
//   req_ready  target can accept this cycle
//   req_we     1 = write, 0 = read
//   req_addr   32-bit byte address
//   req_wdata  write data, little-endian byte lanes
//   req_be     per-lane byte enables (writes only)
//
// Response channel (valid/ready, target -> initiator):
//   rsp_valid  response present
//   rsp_ready  initiator takes the response this cycle
//   rsp_rdata  read data (0 for writes and errors)
//   rsp_err    request was misaligned or out of range
//   rsp_we     echo of the request's req_we
//
// Modports:
//   master  the CPU side that issues requests
//   slave   the memory side that answers them
// ----------------------------------------------------------------------------
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Target end of the CPU memory interface. It accepts one word request per
// cycle on a valid/ready channel, performs the read or byte-masked write on
// an internal word array in the accept cycle, and returns in-order responses
// on a valid/ready channel after a fixed latency. The CPU can stall on
// memory because both channels carry back-pressure.
//
// Parameters:
//   DEPTH    number of 32-bit words in the array
//   LATENCY  cycles from request accept to earliest rsp_valid (1..4)
//   QDEPTH   maximum outstanding requests, accepted but not yet answered (1..4)
//
// Ports:
//   clk      clock
//   reset_n  synchronous active-low reset; clears the request/response
//            machinery but not the array contents
//   bus      mem_responder_if.slave: request and response channels
// ----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input logic            clk,
  input logic            reset_n,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  localparam logic [CNT_W-1:0] QDEPTH_CNT = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(QDEPTH - 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } rsp_t;

  // Circular pointer increment for non-power-of-two FIFO depths.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Request decode and handshake
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             req_ready;
  logic             accept;
  logic [29:0]      word_addr;
  logic [IDX_W-1:0] word_idx;
  logic             addr_err;

  // Ready depends only on the outstanding count so it has no path from
  // rsp_ready; the reset term keeps it low during reset.
  assign req_ready     = reset_n && (outstanding_q < QDEPTH_CNT);
  assign bus.req_ready = req_ready;
  assign accept        = bus.req_valid && req_ready;

  // Out-of-range word addresses are reported, never wrapped.
  assign word_addr = bus.req_addr[31:2];
  assign word_idx  = word_addr[IDX_W-1:0];
  assign addr_err  = (bus.req_addr[1:0] != 2'b00) ||
                     ({2'b00, word_addr} >= 32'(DEPTH));

  // --------------------------------------------------------------------------
  // Word array
  // --------------------------------------------------------------------------
  logic [31:0] mem_array [DEPTH];

  // The array is deliberately outside the reset domain so its contents
  // survive reset; a write commits only at its own accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) begin
          mem_array[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is taken from the array in the accept cycle. A write from the
  // previous cycle has already landed, giving read-after-write ordering.
  rsp_t capture;

  always_comb begin
    capture       = '0;
    capture.we    = bus.req_we;
    capture.err   = addr_err;
    if (!addr_err && !bus.req_we) begin
      capture.rdata = mem_array[word_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Latency pipeline: advances every cycle, back-pressure lives in the FIFO
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  rsp_t               pipe_data_q [LATENCY];
  rsp_t               pipe_data_d [LATENCY];

  always_comb begin
    pipe_vld_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = accept;
    pipe_data_d[0] = capture;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  // Everything in the pipeline plus everything in the FIFO is counted in
  // outstanding, which never exceeds QDEPTH, so a push never meets a full
  // FIFO and no full/overflow handling is needed.
  rsp_t             fifo_q [QDEPTH];
  rsp_t             fifo_d [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             push;
  logic             pop;
  logic             rsp_valid;
  rsp_t             head;

  assign push      = pipe_vld_q[LATENCY-1];
  assign rsp_valid = reset_n && (fifo_cnt_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = pipe_data_q[LATENCY-1];
      wr_ptr_d         = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding request count
  // --------------------------------------------------------------------------
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs: head of the FIFO, forced to zero when nothing is
  // presented so idle and reset values are clean.
  // --------------------------------------------------------------------------
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_valid ? head.rdata : 32'h0;
  assign bus.rsp_err   = rsp_valid ? head.err   : 1'b0;
  assign bus.rsp_we    = rsp_valid ? head.we    : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. Two instances share one stimulus
// driver: dut_a uses the default configuration (QDEPTH 2) and carries most
// scenarios; dut_b uses QDEPTH 4, deep enough for back-to-back accepts at
// LATENCY 2 with a registered req_ready. The driver pushes the expected
// response of each accepted request onto a scoreboard queue; a separate
// monitor pops and compares whenever a response handshake happens.
// All inputs change #1 after a rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int DEPTH   = 4096;
  localparam int LATENCY = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    int          acc;
    bit          chk_lat;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_ready_m;
  logic        rsp_valid_m;
  logic [31:0] rsp_rdata_m;
  logic        rsp_err_m;
  logic        rsp_we_m;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tag_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .QDEPTH(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  // Route the single stimulus set to the selected instance; the idle one
  // sees no requests and an always-ready response channel.
  assign bus_a.req_valid = req_valid & ~sel;
  assign bus_b.req_valid = req_valid &  sel;
  assign bus_a.req_we    = req_we;
  assign bus_b.req_we    = req_we;
  assign bus_a.req_addr  = req_addr;
  assign bus_b.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_wdata = req_wdata;
  assign bus_a.req_be    = req_be;
  assign bus_b.req_be    = req_be;
  assign bus_a.rsp_ready = sel ? 1'b1 : rsp_ready;
  assign bus_b.rsp_ready = sel ? rsp_ready : 1'b1;

  assign req_ready_m = sel ? bus_b.req_ready : bus_a.req_ready;
  assign rsp_valid_m = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign rsp_rdata_m = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign rsp_err_m   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
  assign rsp_we_m    = sel ? bus_b.rsp_we    : bus_a.rsp_we;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Present one request, wait (bounded) for its accept edge, then record the
  // hand-computed expected response with the accept cycle.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit chk_lat, output int acc);
    exp_t e;
    bit   accepted;
    accepted  = 1'b0;
    acc       = -1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (req_ready_m) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    if (accepted) begin
      acc       = cyc;
      e.rdata   = exp_rdata;
      e.err     = exp_err;
      e.we      = we;
      e.acc     = cyc;
      e.chk_lat = chk_lat;
      e.tag     = tag_cnt;
      tag_cnt++;
      sb_q.push_back(e);
    end else begin
      reportTimeout($sformatf("accept addr 0x%08h", addr));
    end
    req_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      reportTimeout(name);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: reset-state checks while reset is low, scoreboard compare on
  // every response handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("reset req_ready", 32'(req_ready_m), 32'h0);
      checkOutput("reset rsp_valid", 32'(rsp_valid_m), 32'h0);
      checkOutput("reset rsp_rdata", rsp_rdata_m, 32'h0);
      checkOutput("reset rsp_err", 32'(rsp_err_m), 32'h0);
      checkOutput("reset rsp_we", 32'(rsp_we_m), 32'h0);
    end else if (rsp_valid_m && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected response: rdata 0x%08h err %0d we %0d, none pending",
                 rsp_rdata_m, rsp_err_m, rsp_we_m);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput($sformatf("rsp%0d rdata", mon_e.tag), rsp_rdata_m, mon_e.rdata);
        checkOutput($sformatf("rsp%0d err", mon_e.tag), 32'(rsp_err_m), 32'(mon_e.err));
        checkOutput($sformatf("rsp%0d we", mon_e.tag), 32'(rsp_we_m), 32'(mon_e.we));
        if (mon_e.chk_lat) begin
          checkOutput($sformatf("rsp%0d latency", mon_e.tag), 32'(cyc - mon_e.acc),
                      32'(LATENCY));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int accs [8];

    reset_n   = 1'b0;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("req_ready after reset", 32'(req_ready_m), 32'h1);
    checkOutput("rsp_valid after reset", 32'(rsp_valid_m), 32'h0);
    @(posedge clk);
    #1;

    $display("[TB] write then read word 4");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, acc);

    $display("[TB] byte-masked write");
    applyStimulus(1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, acc);

    $display("[TB] error cases and top word");
    applyStimulus(1'b1, 32'h0, 32'h01234567, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, acc);
    applyStimulus(1'b1, 32'(4 * (DEPTH - 1)), 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, acc);
    waitDrain("drain after errors");

    $display("[TB] back-pressure with QDEPTH 2");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0, 1'b0, acc);
    fork
      applyStimulus(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0, acc);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checkOutput("req_ready while full", 32'(req_ready_m), 32'h0);
        end
        checkOutput("rsp_valid held", 32'(rsp_valid_m), 32'h1);
        checkOutput("held head rdata", rsp_rdata_m, 32'h11BB33DD);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    waitDrain("drain after back-pressure");

    $display("[TB] throughput on QDEPTH 4 instance");
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 32'h5A000000 | 32'(i * 32'h0101), 4'hF,
                    32'h0, 1'b0, 1'b1, acc);
    end
    waitDrain("drain after preload");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'(4 * i), 32'h0, 4'h0, 32'h5A000000 | 32'(i * 32'h0101),
                    1'b0, 1'b1, accs[i]);
    end
    for (int i = 1; i < 8; i++) begin
      checkOutput($sformatf("accept spacing %0d", i), 32'(accs[i] - accs[0]), 32'(i));
    end
    waitDrain("drain after throughput");
    sel = 1'b0;

    $display("[TB] reset with requests in flight");
    applyStimulus(1'b1, 32'h20, 32'h600DF00D, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    waitDrain("drain before reset");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h01234567, 1'b0, 1'b0, acc);
    reset_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("req_ready after mid reset", 32'(req_ready_m), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no stale response", 32'(rsp_valid_m), 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 1'b1, acc);
    waitDrain("final drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
